// File: rtl/instr_align_queue.sv
// ---------------------------------------------------------------------------
// instr_align_queue
//
// Turns fixed-size, naturally aligned fetch blocks into a stream of
// individually tagged instructions.  The fetch side delivers FETCH_WIDTH
// 32-bit slots together with the PC of the first instruction it actually
// wants.  Leading slots below that PC are dropped, the rest are compacted
// into a circular queue, and the decode side sees up to DECODE_WIDTH of the
// oldest entries every cycle.  A block carrying a fetch exception collapses
// to a single NOP entry that carries the exception to decode.
//
// Ports
//   i_clk      clock
//   i_rst_n    synchronous active-low reset (queue pointers only)
//   i_flush    drop everything queued and whatever arrives this cycle
//   i_valid    fetch block offered
//   i_pc       PC of the first wanted instruction (word aligned)
//   i_data     fetch block, slot k at [32k+31:32k]
//   i_except   fetch exception attached to the block
//   o_ready    block is taken this cycle if i_valid (registered count only)
//   o_valid    per-slot valid towards decode, thermometer from bit 0
//   o_instrs   presented entries, slot 0 oldest, all-zero when not valid
//   i_ready    decode takes every valid presented slot this cycle
//
// The shared types below live at compilation-unit scope so that both the
// queue and anything connecting to it see one definition.
// ---------------------------------------------------------------------------

typedef logic [31:0] program_counter_t;

typedef struct packed {
   logic       valid;
   logic [3:0] cause;
} except_t;

typedef struct packed {
   logic             valid;
   program_counter_t pc;
   logic [31:0]      instr;
   except_t          except;
} aligned_instr_t;

// addi x0, x0, 0 -- stands in for the instruction word of a faulting fetch
localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

function automatic aligned_instr_t compose_aligned_instr(
   input program_counter_t pc,
   input logic [31:0]      instr,
   input except_t          except
);
   aligned_instr_t e;
   e.valid  = 1'b1;
   e.pc     = pc;
   e.instr  = instr;
   e.except = except;
   return e;
endfunction

module instr_align_queue #(
   parameter int FETCH_WIDTH  = 2,
   parameter int DECODE_WIDTH = 2,
   parameter int DEPTH        = 8
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_flush,
   input  logic                                 i_valid,
   input  program_counter_t                     i_pc,
   input  logic [32*FETCH_WIDTH-1:0]            i_data,
   input  except_t                              i_except,
   output logic                                 o_ready,
   output logic [DECODE_WIDTH-1:0]              o_valid,
   output aligned_instr_t [DECODE_WIDTH-1:0]    o_instrs,
   input  logic                                 i_ready
);

   localparam int OFF_W = $clog2(FETCH_WIDTH);
   localparam int B     = OFF_W + 2;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Reject parameter sets the pointer arithmetic below cannot handle.
   generate
      if (FETCH_WIDTH < 2 || FETCH_WIDTH > 8 || (FETCH_WIDTH & (FETCH_WIDTH - 1)) != 0) begin : g_bad_fw
         $error("FETCH_WIDTH must be a power of 2 in 2..8");
      end
      if (DECODE_WIDTH < 1 || DECODE_WIDTH > FETCH_WIDTH) begin : g_bad_dw
         $error("DECODE_WIDTH must be in 1..FETCH_WIDTH");
      end
      if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * FETCH_WIDTH) begin : g_bad_depth
         $error("DEPTH must be a power of 2 and at least 2*FETCH_WIDTH");
      end
   endgenerate

   // Queue control state
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Entry storage; never reset, reads are masked by count_q
   aligned_instr_t   mem_q [DEPTH];
   aligned_instr_t   mem_d [DEPTH];

   // Incoming block, already compacted to positions 0..enq_n-1
   aligned_instr_t   enq_ent [FETCH_WIDTH];
   logic [CNT_W-1:0] enq_n;
   logic [CNT_W-1:0] deq_n;
   logic [OFF_W-1:0] offset;
   logic             enq_fire;
   logic             deq_fire;

   // The two PC bits below word alignment carry no information here.
   logic             unused_pc_lsb;
   assign unused_pc_lsb = ^i_pc[1:0];

   // Only the registered count is consulted, so a dequeue arriving in the
   // same cycle never opens the door early.
   assign o_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);

   // ------------------------------------------------------------------
   // Block alignment: slot (i + offset) of the fetch block lands in
   // compacted position i.  A faulting block becomes a single NOP.
   // ------------------------------------------------------------------
   always_comb begin
      offset = i_pc[B-1:2];
      enq_n  = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         enq_ent[i] = '0;
      end

      if (i_except.valid) begin
         enq_ent[0] = compose_aligned_instr(i_pc, NOP_ENCODING, i_except);
         enq_n      = CNT_W'(1);
      end else begin
         enq_n = CNT_W'(FETCH_WIDTH) - CNT_W'(offset);
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (i + int'(offset) < FETCH_WIDTH) begin
               enq_ent[i] = compose_aligned_instr(
                  {i_pc[31:B], OFF_W'(i + int'(offset)), 2'b00},
                  i_data[32*(i + int'(offset)) +: 32],
                  '0);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Pointer / count update.  Enqueue and dequeue are independent because
   // o_ready guarantees room for a whole block before any dequeue.
   // ------------------------------------------------------------------
   always_comb begin
      enq_fire = i_valid & o_ready & ~i_flush;
      deq_fire = i_ready & ~i_flush;

      deq_n = '0;
      if (deq_fire) begin
         deq_n = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
      end

      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + (enq_fire ? PTR_W'(enq_n) : '0);
      count_d = count_q + (enq_fire ? enq_n : '0) - deq_n;

      // Flush wins over anything that would otherwise happen this cycle.
      if (i_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Storage write: positions past enq_n are left untouched.
   always_comb begin
      mem_d = mem_q;
      if (enq_fire) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (CNT_W'(i) < enq_n) begin
               mem_d[tail_q + PTR_W'(i)] = enq_ent[i];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   // ------------------------------------------------------------------
   // Presentation: purely from registered state, so a newly accepted
   // block shows up one cycle after acceptance.
   // ------------------------------------------------------------------
   always_comb begin
      o_valid  = '0;
      o_instrs = '0;
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         if (count_q > CNT_W'(j)) begin
            o_valid[j]  = 1'b1;
            o_instrs[j] = mem_q[head_q + PTR_W'(j)];
         end
      end
   end

endmodule
